// File: rtl/icache_pkg.sv
// Shared geometry, state encoding and helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned TAG_W    = 3;
    localparam int unsigned INDEX_W  = 3;
    localparam int unsigned OFFSET_W = 2;
    localparam int unsigned WORDS    = 4;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned LINE_W   = 128;
    localparam int unsigned LINES    = 2 ** INDEX_W;
    localparam int unsigned BLK_W    = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM_RD = 2'd1,
        UPDATE = 2'd2
    } state_t;

    typedef logic [TAG_W-1:0]    tag_t;
    typedef logic [INDEX_W-1:0]  index_t;
    typedef logic [OFFSET_W-1:0] offset_t;

    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input offset_t            off);
        return line[off*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read port, one synchronous write port,
// valid bits cleared on RESET (tags and data are left untouched).
module icache_array
    import icache_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  index_t            rd_index,
    output logic              rd_valid,
    output tag_t              rd_tag,
    output logic [LINE_W-1:0] rd_data,
    input  logic              wr_en,
    input  index_t            wr_index,
    input  tag_t              wr_tag,
    input  logic [LINE_W-1:0] wr_data
);

    logic [LINES-1:0]  valid;
    tag_t              tag_arr  [LINES];
    logic [LINE_W-1:0] data_arr [LINES];

    always_ff @(posedge CLK) begin
        if (RESET)
            valid <= '0;
        else if (wr_en)
            valid[wr_index] <= 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tag_arr[wr_index]  <= wr_tag;
            data_arr[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_arr[rd_index];
    assign rd_data  = data_arr[rd_index];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: zero-stall hits, whole-line refill
// from instruction memory on a miss via a read/busywait handshake.
module instr_cache
    import icache_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic [ADDR_W-1:0]  PC_ADDR,
    output logic [WORD_W-1:0]  INSTRUCTION,
    output logic               BUSYWAIT,
    output logic               MEM_READ,
    output logic [BLK_W-1:0]   MEM_ADDRESS,
    input  logic [LINE_W-1:0]  MEM_READDATA,
    input  logic               MEM_BUSYWAIT
);

    state_t            state, next_state;
    tag_t              pc_tag;
    index_t            pc_index;
    offset_t           pc_offset;
    logic [BLK_W-1:0]  miss_addr;
    logic [LINE_W-1:0] fill_buf;
    logic              rd_valid;
    tag_t              rd_tag;
    logic [LINE_W-1:0] rd_data;
    logic              hit;
    logic              fill_we;
    logic              unused_pc_bits;

    assign pc_tag         = PC_ADDR[ADDR_W-1 -: TAG_W];
    assign pc_index       = PC_ADDR[ADDR_W-TAG_W-1 -: INDEX_W];
    assign pc_offset      = PC_ADDR[OFFSET_W+1:2];
    assign unused_pc_bits = ^PC_ADDR[1:0];

    icache_array u_array (
        .CLK      (CLK),
        .RESET    (RESET),
        .rd_index (pc_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill_we),
        .wr_index (miss_addr[INDEX_W-1:0]),
        .wr_tag   (miss_addr[BLK_W-1:INDEX_W]),
        .wr_data  (fill_buf)
    );

    assign hit         = rd_valid && (rd_tag == pc_tag);
    assign INSTRUCTION = line_word(rd_data, pc_offset);

    always_ff @(posedge CLK) begin
        if (RESET)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Refill is driven solely by miss_addr, so PC changes mid-miss are ignored.
    always_ff @(posedge CLK) begin
        if (RESET)
            miss_addr <= '0;
        else if (state == IDLE && !hit)
            miss_addr <= {pc_tag, pc_index};
    end

    always_ff @(posedge CLK) begin
        if (state == MEM_RD && !MEM_BUSYWAIT)
            fill_buf <= MEM_READDATA;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!hit) next_state = MEM_RD;
            MEM_RD:  if (!MEM_BUSYWAIT) next_state = UPDATE;
            UPDATE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        BUSYWAIT    = 1'b0;
        MEM_READ    = 1'b0;
        MEM_ADDRESS = '0;
        fill_we     = 1'b0;
        if (!RESET) begin
            BUSYWAIT = (state != IDLE) || !hit;
            case (state)
                MEM_RD: begin
                    MEM_READ    = 1'b1;
                    MEM_ADDRESS = miss_addr;
                end
                UPDATE:  fill_we = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: behavioural instruction memory with a
// programmable busy latency, table-driven hit vectors and directed miss sequences.
module tb_instr_cache;

    logic         CLK;
    logic         RESET;
    logic [9:0]   PC_ADDR;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    int unsigned  n_tests = 0;
    int unsigned  n_fail  = 0;

    int unsigned  mem_lat;
    int unsigned  busy_cnt;
    logic         ovr_en;
    logic         ovr_val;

    typedef struct {
        logic [9:0]  pc;
        logic        busy;
        logic [31:0] instr;
    } vec_t;

    vec_t tbl[$];

    instr_cache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC_ADDR      (PC_ADDR),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Each word holds 0xC0DE0000 plus its own byte address.
    function automatic logic [31:0] memword(input logic [9:0] addr);
        return 32'hC0DE_0000 | {22'b0, addr[9:2], 2'b00};
    endfunction

    function automatic logic [127:0] mem_block(input logic [5:0] blk);
        logic [127:0] line;
        logic [1:0]   w;
        line = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w = i[1:0];
            line[i*32 +: 32] = memword({blk, w, 2'b00});
        end
        return line;
    endfunction

    always @(posedge CLK) begin
        if (MEM_READ) begin
            if (busy_cnt < mem_lat)
                busy_cnt <= busy_cnt + 1;
        end else begin
            busy_cnt <= 0;
        end
    end

    always_comb begin
        MEM_BUSYWAIT = ovr_en ? ovr_val : (MEM_READ && (busy_cnt < mem_lat));
        MEM_READDATA = mem_block(MEM_ADDRESS);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic apply_table(input string nm);
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge CLK); #1 PC_ADDR = tbl[i].pc;
            @(negedge CLK);
            chk($sformatf("%s busy pc=%0h", nm, tbl[i].pc), {31'b0, BUSYWAIT}, {31'b0, tbl[i].busy});
            chk($sformatf("%s mem_read pc=%0h", nm, tbl[i].pc), {31'b0, MEM_READ}, 32'd0);
            chk($sformatf("%s instr pc=%0h", nm, tbl[i].pc), INSTRUCTION, tbl[i].instr);
        end
    endtask

    // Full miss: detect cycle, mem_lat busy MEM_RD cycles, one ready MEM_RD cycle, UPDATE.
    task automatic do_miss(input string nm, input logic [9:0] pc, input logic [5:0] blk);
        int unsigned rd   = 0;
        int unsigned bw   = 0;
        bit          seen = 0;
        @(posedge CLK); #1 RESET = 1'b0; PC_ADDR = pc;
        @(negedge CLK);
        chk({nm, " detect busy"}, {31'b0, BUSYWAIT}, 32'd1);
        chk({nm, " detect mem_read"}, {31'b0, MEM_READ}, 32'd0);
        while (BUSYWAIT && bw < 40) begin
            bw++;
            if (MEM_READ) begin
                rd++;
                if (!seen) begin
                    seen = 1;
                    chk({nm, " mem_address"}, {26'b0, MEM_ADDRESS}, {26'b0, blk});
                end
            end
            @(negedge CLK);
        end
        chk({nm, " refill done"}, {31'b0, BUSYWAIT}, 32'd0);
        chk({nm, " mem_read cycles"}, rd, mem_lat + 1);
        chk({nm, " busy cycles"}, bw, mem_lat + 3);
        chk({nm, " instr"}, INSTRUCTION, memword(pc));
    endtask

    initial begin
        int unsigned k;
        RESET   = 1'b1;
        PC_ADDR = 10'h000;
        mem_lat = 5;
        ovr_en  = 1'b0;
        ovr_val = 1'b1;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset busywait", {31'b0, BUSYWAIT}, 32'd0);
        chk("reset mem_read", {31'b0, MEM_READ}, 32'd0);
        chk("reset mem_address", {26'b0, MEM_ADDRESS}, 32'd0);

        // Cold miss on block 0
        do_miss("t1 cold", 10'h000, 6'h00);

        // Hits within block 0
        tbl.push_back('{pc: 10'h004, busy: 1'b0, instr: 32'hC0DE_0004});
        tbl.push_back('{pc: 10'h008, busy: 1'b0, instr: 32'hC0DE_0008});
        tbl.push_back('{pc: 10'h00C, busy: 1'b0, instr: 32'hC0DE_000C});
        tbl.push_back('{pc: 10'h002, busy: 1'b0, instr: 32'hC0DE_0000});
        apply_table("t2 hit");

        // Conflict: block 8 evicts block 0 from line 0, then block 0 misses again
        do_miss("t3 blk8", 10'h080, 6'h08);
        tbl.delete();
        tbl.push_back('{pc: 10'h084, busy: 1'b0, instr: 32'hC0DE_0084});
        tbl.push_back('{pc: 10'h08C, busy: 1'b0, instr: 32'hC0DE_008C});
        apply_table("t3 hit blk8");
        do_miss("t3 conflict", 10'h000, 6'h00);

        // Top address with an immediately ready memory, then wrap to 0x000 (line 0 still valid)
        mem_lat = 0;
        do_miss("t5 top", 10'h3FC, 6'h3F);
        tbl.delete();
        tbl.push_back('{pc: 10'h3F0, busy: 1'b0, instr: 32'hC0DE_03F0});
        tbl.push_back('{pc: 10'h000, busy: 1'b0, instr: 32'hC0DE_0000});
        apply_table("t5 wrap");
        mem_lat = 5;

        // Reset during MEM_RD with a memory response arriving in the same cycle
        @(posedge CLK); #1 PC_ADDR = 10'h010;
        k = 0;
        @(negedge CLK);
        while (!MEM_READ && k < 10) begin
            k++;
            @(negedge CLK);
        end
        chk("t4 reached mem_rd", {31'b0, MEM_READ}, 32'd1);
        @(posedge CLK); #1 RESET = 1'b1; ovr_en = 1'b1; ovr_val = 1'b0;
        @(negedge CLK);
        chk("t4 busywait in reset", {31'b0, BUSYWAIT}, 32'd0);
        @(posedge CLK); #1 RESET = 1'b0; ovr_en = 1'b0; PC_ADDR = 10'h000;
        @(negedge CLK);
        chk("t4 mem_read after reset", {31'b0, MEM_READ}, 32'd0);
        chk("t4 line0 invalidated", {31'b0, BUSYWAIT}, 32'd1);
        @(negedge CLK);
        chk("t4 refill mem_read", {31'b0, MEM_READ}, 32'd1);
        chk("t4 refill mem_address", {26'b0, MEM_ADDRESS}, 32'd0);
        k = 0;
        while (BUSYWAIT && k < 40) begin
            k++;
            @(negedge CLK);
        end
        chk("t4 refill done", {31'b0, BUSYWAIT}, 32'd0);
        chk("t4 refill instr", INSTRUCTION, 32'hC0DE_0000);
        do_miss("t4 no late fill", 10'h010, 6'h01);

        // PC toggles during MEM_RD must not disturb the latched miss address
        @(posedge CLK); #1 PC_ADDR = 10'h020;
        @(negedge CLK);
        chk("t6 detect busy", {31'b0, BUSYWAIT}, 32'd1);
        @(posedge CLK); #1 PC_ADDR = 10'h0A0;
        @(negedge CLK);
        k = 0;
        while (MEM_READ && k < 40) begin
            chk($sformatf("t6 mem_address c%0d", k), {26'b0, MEM_ADDRESS}, 32'h02);
            @(posedge CLK); #1 PC_ADDR = k[0] ? 10'h0A0 : 10'h030;
            k++;
            @(negedge CLK);
        end
        chk("t6 mem_read cycles", k, mem_lat + 1);
        @(posedge CLK); #1 PC_ADDR = 10'h020;
        @(negedge CLK);
        chk("t6 orig index hit", {31'b0, BUSYWAIT}, 32'd0);
        chk("t6 orig index instr", INSTRUCTION, 32'hC0DE_0020);
        @(posedge CLK); #1 PC_ADDR = 10'h030;
        @(negedge CLK);
        chk("t6 idx3 not filled", {31'b0, BUSYWAIT}, 32'd1);
        @(negedge CLK);
        chk("t6 idx3 mem_address", {26'b0, MEM_ADDRESS}, 32'h03);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
